instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: DEPTH, 4, output FIFO entries (power of two, 2..16).
REQ-002 Parameter: BASE_ADDR, 32'h0000_0000, byte address given to the first emitted word.
REQ-003 Port: clk  input  1  rising-edge clock, the only clock.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  encode request present.
REQ-006 Port: in_ready  output  1  request accepted on a clk edge where in_valid&in_ready.
REQ-007 Port: in_class  input  3  0=R, 1=LOAD, 2=STORE, 3=BRANCH, 4=IMM(OP-IMM), 5=JAL, 6=JALR, 7=illegal.
REQ-008 Port: in_funct3  input  3  funct3 field.
REQ-009 Port: in_funct7b5  input  1  instruction bit 30 (SUB/SRA/SRAI).
REQ-010 Port: in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-011 Port: in_imm  input  32  signed immediate, byte offset for BRANCH/JAL.
REQ-012 Port: out_valid  output  1  encoded word available.
REQ-013 Port: out_ready  input  1  consumer takes word on a clk edge where out_valid&out_ready.
REQ-014 Port: out_instr  output  32  encoded RV32I word (FIFO head).
REQ-015 Port: out_addr  output  32  byte address of head word.
REQ-016 Port: err  output  1  one-cycle pulse when an accepted request is dropped.

Function
REQ-017 Opcodes SHALL be R=0110011, LOAD=0000011, STORE=0100011, BRANCH=1100011, IMM=0010011, JAL=1101111, JALR=1100111.
REQ-018 R: {1'b0,funct7b5,5'b0,rs2,rs1,funct3,rd,op}; IMM: {imm[11:0],rs1,funct3,rd,op}, except funct3=001/101: {1'b0,funct7b5,5'b0,imm[4:0],rs1,funct3,rd,op}.
REQ-019 LOAD/JALR: {imm[11:0],rs1,funct3,rd,op}; JALR funct3 forced to 000.
REQ-020 STORE: {imm[11:5],rs2,rs1,funct3,imm[4:0],op}.
REQ-021 BRANCH: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}; JAL: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-022 Unused fields of an input class SHALL be ignored, never leaking into the word.
REQ-023 Encoding SHALL be registered: word accepted at edge N is presented (out_valid=1) after edge N when FIFO was empty; no combinational in-to-out path.
REQ-024 in_ready SHALL equal !full; a push is never accepted when full, even with a simultaneous pop.
REQ-025 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged and preserve order.
REQ-026 out_valid SHALL equal !empty; out_instr/out_addr SHALL be stable while out_valid&!out_ready.
REQ-027 Address counter SHALL start at BASE_ADDR, increment by 4 per accepted (pushed) word, wrap modulo 2^32; each FIFO entry stores its own address.
REQ-028 in_class=7 SHALL be accepted (consumed) when in_ready=1, not pushed, not advance the address, and pulse err the following cycle.
REQ-029 FIFO read/write pointers SHALL wrap modulo DEPTH; occupancy counter 0..DEPTH.

Reset
REQ-030 On reset at a clk edge: FIFO emptied, address counter=BASE_ADDR, out_valid=0, in_ready=1 after the edge, err=0, out_instr=0, out_addr=BASE_ADDR.
REQ-031 Reset SHALL take precedence over any simultaneous push/pop; in-flight entries are discarded.

Configuration
REQ-032 Macro IMM_RANGE_CHECK_EN: when defined, an accepted request whose in_imm exceeds its field (I/S: signed 12-bit; B: signed 13-bit, bit0=0; J: signed 21-bit, bit0=0; shift: imm[31:5]!=0) SHALL be dropped as in REQ-028 with err pulse.
REQ-033 Without IMM_RANGE_CHECK_EN, out-of-range immediates SHALL be silently truncated per REQ-018..021 and err pulses only for class 7.

Verification
REQ-034 R class, funct3=000, funct7b5=1, rd=3, rs1=1, rs2=2 -> out_instr=32'h402081B3 at out_addr=BASE_ADDR.
REQ-035 BRANCH funct3=001, rs1=5, rs2=6, imm=-8 -> 32'hFE629CE3; JAL rd=1, imm=2048 -> 32'h001000EF.
REQ-036 out_ready=0, push DEPTH+1 requests -> in_ready=0 after DEPTH pushes; release -> words drained in order, addresses BASE_ADDR+0,+4,+8,+12.
REQ-037 class 7 between two valid requests -> single err pulse, second valid word at BASE_ADDR+4; with IMM_RANGE_CHECK_EN, IMM imm=4096 -> err, nothing pushed.
REQ-038 Reset asserted with 3 entries queued and push/pop active -> next cycle out_valid=0, in_ready=1, next pushed word at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: encode-request side (in_*),
// encoded-word FIFO side (out_*) and the drop/error pulse.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_class;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;

    modport master (
        output in_valid, in_class, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err
    );

    modport slave (
        input  in_valid, in_class, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_addr, err
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder feeding a DEPTH-entry FIFO of {word, byte address}.
// Optional macro IMM_RANGE_CHECK_EN drops requests whose immediate overflows its field.
module instr_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic            clk,
    input logic            reset,
    instr_encoder_if.slave bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_IMM    = 3'd4,
        CLS_JAL    = 3'd5,
        CLS_JALR   = 3'd6,
        CLS_ILL    = 3'd7
    } cls_e;

    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   addr_mem_q  [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   addr_q, addr_d;
    logic          err_q, err_d;

    logic [31:0] enc_word;
    logic        imm_bad;
    logic        full, empty, accept, drop, push, pop;
    cls_e        cls;
    logic [31:0] imm;
    logic        is_shift;

    assign cls      = cls_e'(bus.in_class);
    assign imm      = bus.in_imm;
    assign is_shift = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101);

    always_comb begin
        enc_word = '0;
        unique case (cls)
            CLS_R:      enc_word = {1'b0, bus.in_funct7b5, 5'b0, bus.in_rs2, bus.in_rs1,
                                    bus.in_funct3, bus.in_rd, OP_R};
            CLS_LOAD:   enc_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_LOAD};
            CLS_STORE:  enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                    imm[4:0], OP_STORE};
            CLS_BRANCH: enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                    imm[4:1], imm[11], OP_BRANCH};
            CLS_IMM:    enc_word = is_shift
                                 ? {1'b0, bus.in_funct7b5, 5'b0, imm[4:0], bus.in_rs1,
                                    bus.in_funct3, bus.in_rd, OP_IMM}
                                 : {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_IMM};
            CLS_JAL:    enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, OP_JAL};
            CLS_JALR:   enc_word = {imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, OP_JALR};
            default:    enc_word = '0;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    always_comb begin
        imm_bad = 1'b0;
        unique case (cls)
            CLS_LOAD, CLS_STORE, CLS_JALR:
                imm_bad = (imm[31:11] != {21{imm[11]}});
            CLS_IMM:
                imm_bad = is_shift ? (|imm[31:5]) : (imm[31:11] != {21{imm[11]}});
            CLS_BRANCH:
                imm_bad = (imm[31:12] != {20{imm[12]}}) | imm[0];
            CLS_JAL:
                imm_bad = (imm[31:20] != {12{imm[20]}}) | imm[0];
            default:
                imm_bad = 1'b0;
        endcase
    end
`else
    assign imm_bad = 1'b0;
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm[31:21];
`endif

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign accept = bus.in_valid & ~full;
    assign drop   = (cls == CLS_ILL) | imm_bad;
    assign push   = accept & ~drop;
    assign pop    = ~empty & bus.out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        err_d    = accept & drop;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            addr_d   = addr_q + 32'd4;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        // push is gated by !full, so push&pop can never overflow the counter
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= BASE_ADDR;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            instr_mem_q[wr_ptr_q] <= enc_word;
            addr_mem_q[wr_ptr_q]  <= addr_q;
        end
    end

    // Storage is not reset; an empty FIFO presents zero and the next push address.
    assign bus.out_valid = ~empty;
    assign bus.in_ready  = ~full;
    assign bus.out_instr = empty ? '0 : instr_mem_q[rd_ptr_q];
    assign bus.out_addr  = empty ? addr_q : addr_mem_q[rd_ptr_q];
    assign bus.err       = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Randomised bench for instr_encoder against a queue-based reference model
// that builds words with shift/mask arithmetic straight from the ISA field layout.
module tb_instr_encoder;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic clk = 1'b0;
    logic reset;

    instr_encoder_if bus ();

    instr_encoder #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    logic [63:0] model_q[$];
    logic [31:0] exp_addr = BASE;
    logic        exp_err  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [2:0] c, input logic [2:0] f3,
                                             input logic f7, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [31:0] u);
        logic [31:0] rdf, f3f, r1f, r2f, f7f;
        rdf = 32'(rd) << 7;
        f3f = 32'(f3) << 12;
        r1f = 32'(rs1) << 15;
        r2f = 32'(rs2) << 20;
        f7f = 32'(f7) << 30;
        case (c)
            3'd0: return 32'h33 | rdf | f3f | r1f | r2f | f7f;
            3'd1: return 32'h03 | rdf | f3f | r1f | ((u & 32'hFFF) << 20);
            3'd2: return 32'h23 | ((u & 32'h1F) << 7) | f3f | r1f | r2f | (((u >> 5) & 32'h7F) << 25);
            3'd3: return 32'h63 | (((u >> 11) & 32'h1) << 7) | (((u >> 1) & 32'hF) << 8) | f3f | r1f | r2f
                         | (((u >> 5) & 32'h3F) << 25) | (((u >> 12) & 32'h1) << 31);
            3'd4: if (f3 == 3'd1 || f3 == 3'd5)
                      return 32'h13 | rdf | f3f | r1f | ((u % 32) << 20) | f7f;
                  else
                      return 32'h13 | rdf | f3f | r1f | ((u & 32'hFFF) << 20);
            3'd5: return 32'h6F | rdf | (((u >> 12) & 32'hFF) << 12) | (((u >> 11) & 32'h1) << 20)
                         | (((u >> 1) & 32'h3FF) << 21) | (((u >> 20) & 32'h1) << 31);
            3'd6: return 32'h67 | rdf | r1f | ((u & 32'hFFF) << 20);
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit imm_ok(input logic [2:0] c, input logic [2:0] f3, input logic [31:0] u);
`ifdef IMM_RANGE_CHECK_EN
        int s;
        s = int'(signed'(u));
        case (c)
            3'd1, 3'd2, 3'd6: return (s >= -2048 && s <= 2047);
            3'd4: if (f3 == 3'd1 || f3 == 3'd5) return (u < 32);
                  else return (s >= -2048 && s <= 2047);
            3'd3: return (s >= -4096 && s <= 4095 && (s % 2) == 0);
            3'd5: return (s >= -1048576 && s <= 1048575 && (s % 2) == 0);
            default: return 1'b1;
        endcase
`else
        return 1'b1;
`endif
    endfunction

    task automatic compare_all();
        check("out_valid", 32'(bus.out_valid), 32'(model_q.size() != 0));
        check("in_ready", 32'(bus.in_ready), 32'(model_q.size() < DEPTH));
        check("err", 32'(bus.err), 32'(exp_err));
        if (model_q.size() != 0) begin
            check("out_instr", bus.out_instr, model_q[0][63:32]);
            check("out_addr", bus.out_addr, model_q[0][31:0]);
        end
    endtask

    task automatic step(input logic v, input logic [2:0] c, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic ordy, input logic rst);
        bit acc, pp, bad;
        bus.in_valid    = v;
        bus.in_class    = c;
        bus.in_funct3   = f3;
        bus.in_funct7b5 = f7;
        bus.in_rd       = rd;
        bus.in_rs1      = rs1;
        bus.in_rs2      = rs2;
        bus.in_imm      = imm;
        bus.out_ready   = ordy;
        reset           = rst;
        acc = v && (model_q.size() < DEPTH);
        pp  = (model_q.size() > 0) && ordy;
        bad = (c == 3'd7) || !imm_ok(c, f3, imm);
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            exp_addr = BASE;
            exp_err  = 1'b0;
        end else begin
            if (pp) void'(model_q.pop_front());
            if (acc && !bad) begin
                model_q.push_back({ref_word(c, f3, f7, rd, rs1, rs2, imm), exp_addr});
                exp_addr = exp_addr + 32'd4;
            end
            exp_err = acc && bad;
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, ordy, 1'b0);
    endtask

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 127)) - 32'd64;
            1: return 32'($urandom_range(0, 8191)) - 32'd4096;
            2: return $urandom;
            default: return (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
        endcase
    endfunction

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        reset = 1'b1;

        // reset state
        step(1'b0, 3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1);
        check("rst_out_instr", bus.out_instr, 32'h0);
        check("rst_out_addr", bus.out_addr, BASE);

        // known-good encodings
        step(1'b1, 3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("r_sub_word", bus.out_instr, 32'h402081B3);
        check("r_sub_addr", bus.out_addr, BASE);
        step(1'b1, 3'd3, 3'd1, 1'b1, 5'd31, 5'd5, 5'd6, -32'sd8, 1'b1, 1'b0);
        check("bne_word", bus.out_instr, 32'hFE629CE3);
        step(1'b1, 3'd5, 3'd7, 1'b1, 5'd1, 5'd9, 5'd9, 32'd2048, 1'b1, 1'b0);
        check("jal_word", bus.out_instr, 32'h001000EF);
        idle(1'b1);

        // fill past depth with consumer stalled, then drain
        for (int unsigned i = 0; i < DEPTH + 1; i++)
            step(1'b1, 3'd1, 3'd2, 1'b0, 5'(i + 1), 5'd2, 5'd0, 32'(i * 4), 1'b0, 1'b0);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        for (int unsigned i = 0; i < DEPTH + 2; i++) idle(1'b1);

        // illegal class between two valid requests
        step(1'b1, 3'd4, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd5, 1'b0, 1'b0);
        step(1'b1, 3'd7, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd5, 1'b0, 1'b0);
        step(1'b1, 3'd2, 3'd2, 1'b0, 5'd0, 5'd3, 5'd4, 32'd16, 1'b0, 1'b0);
        step(1'b1, 3'd4, 3'd0, 1'b0, 5'd2, 5'd2, 5'd0, 32'd4096, 1'b0, 1'b0);
        for (int unsigned i = 0; i < DEPTH + 1; i++) idle(1'b1);

        // reset with entries queued and both sides active
        for (int unsigned i = 0; i < 3; i++)
            step(1'b1, 3'd0, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 1'b0);
        step(1'b1, 3'd0, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1, 1'b1);
        check("rst2_out_valid", 32'(bus.out_valid), 32'd0);
        step(1'b1, 3'd6, 3'd5, 1'b0, 5'd7, 5'd8, 5'd0, 32'd12, 1'b0, 1'b0);
        check("rst2_next_addr", bus.out_addr, BASE);
        idle(1'b1);

        // random traffic
        for (int unsigned i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 7, 3'($urandom), 3'($urandom), 1'($urandom),
                 5'($urandom), 5'($urandom), 5'($urandom), rand_imm(),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
